red_pitaya_asg_sweep: RTL

Frequency-sweep controller that sits directly upstream of an ASG channel and drives that channel's phase-step input (set_step_i).
- Once started, it walks the step from a start value to a stop value in fixed increments, holding each step for a programmable number of DAC clocks.
- Modes: single sweep, repeating sawtooth, or continuous triangle.
- Used for chirp and frequency-response generation without CPU involvement per step.

---
 rtl/red_pitaya_asg_sweep_if.sv | 31 +++
 rtl/red_pitaya_asg_sweep.sv | 112 +++++++++++
 2 files changed

// File: rtl/red_pitaya_asg_sweep_if.sv
// Control/status bundle between a sweep master (CPU regs or bench) and the
// sweep controller that feeds an ASG channel's phase step.
interface red_pitaya_asg_sweep_if #(
  parameter int RSZ = 14,
  parameter int DW  = 32
);
  logic              set_en_i;
  logic [1:0]        set_mode_i;
  logic [RSZ+15:0]   set_start_i;
  logic [RSZ+15:0]   set_stop_i;
  logic [RSZ+15:0]   set_inc_i;
  logic [DW-1:0]     set_dwell_i;
  logic              start_i;
  logic              stop_i;
  logic [RSZ+15:0]   step_o;
  logic              step_upd_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output set_en_i, set_mode_i, set_start_i, set_stop_i, set_inc_i,
           set_dwell_i, start_i, stop_i,
    input  step_o, step_upd_o, busy_o, done_o
  );

  modport slave (
    input  set_en_i, set_mode_i, set_start_i, set_stop_i, set_inc_i,
           set_dwell_i, start_i, stop_i,
    output step_o, step_upd_o, busy_o, done_o
  );
endinterface

// File: rtl/red_pitaya_asg_sweep.sv
// Frequency-sweep controller: ramps an ASG phase step from start to stop in
// clamped increments, holding each value for a programmable dwell.
module red_pitaya_asg_sweep #(
  parameter int RSZ = 14,
  parameter int DW  = 32
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rstn_i,
  red_pitaya_asg_sweep_if.slave sw
);
  localparam int SW = RSZ + 16;

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t          state_q;
  logic [SW-1:0]   step_q;
  logic [DW-1:0]   cnt_q;
  logic            upd_q;
  logic            busy_q;
  logic            done_q;
  logic            dir_up_q;
  logic            wrap_q;

  logic [DW-1:0]   dwell_m1_d;
  logic            going_up_d;
  logic [SW-1:0]   target_d;
  logic [SW:0]     sum_d;
  logic            hit_d;
  logic [SW-1:0]   nxt_d;

  // REV always heads back to start, i.e. opposite to the latched direction.
  always_comb begin
    dwell_m1_d = (sw.set_dwell_i == '0) ? '0 : sw.set_dwell_i - DW'(1);
    going_up_d = (state_q == REV) ? ~dir_up_q : dir_up_q;
    target_d   = (state_q == REV) ? sw.set_start_i : sw.set_stop_i;
    sum_d      = {1'b0, step_q} + {1'b0, sw.set_inc_i};
    if (going_up_d)
      hit_d = (sum_d >= {1'b0, target_d});
    else
      hit_d = (step_q < sw.set_inc_i) || ((step_q - sw.set_inc_i) <= target_d);
    if (hit_d)
      nxt_d = target_d;
    else if (going_up_d)
      nxt_d = sum_d[SW-1:0];
    else
      nxt_d = step_q - sw.set_inc_i;
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q  <= IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_up_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      upd_q  <= 1'b0;
      done_q <= 1'b0;
      if (!sw.set_en_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        wrap_q  <= 1'b0;
        step_q  <= sw.set_start_i;
      end else if (sw.stop_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end else if (sw.start_i) begin
        state_q  <= FWD;
        busy_q   <= 1'b1;
        upd_q    <= 1'b1;
        wrap_q   <= 1'b0;
        step_q   <= sw.set_start_i;
        cnt_q    <= dwell_m1_d;
        dir_up_q <= (sw.set_start_i <= sw.set_stop_i);
      end else if (state_q != IDLE) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - DW'(1);
        end else begin
          cnt_q <= dwell_m1_d;
          upd_q <= 1'b1;
          if (wrap_q) begin
            // sawtooth: the dwell after the endpoint restarts from start
            step_q <= sw.set_start_i;
            wrap_q <= 1'b0;
          end else begin
            step_q <= nxt_d;
            if (hit_d) begin
              case (sw.set_mode_i)
                2'd1: wrap_q <= 1'b1;
                2'd2: state_q <= (state_q == FWD) ? REV : FWD;
                default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              endcase
            end
          end
        end
      end
    end
  end

  assign sw.step_o     = step_q;
  assign sw.step_upd_o = upd_q;
  assign sw.busy_o     = busy_q;
  assign sw.done_o     = done_q;
endmodule
